rptr_handler: RTL and testbench

- Read-side pointer and flag logic for the 32 x 8 asynchronous FIFO. It is the counterpart of the write-side pointer handler and lives entirely in the read clock domain.
- Brings the write-domain Gray pointer across the domain through a 2-flop synchronizer and maintains the binary read address and Gray read pointer.
- Generates empty, almost_empty, fill count and a sticky underflow flag.
- rptr feeds the write domain's synchronizer. raddr[WIDTH-1:0] addresses the FIFO memory read port.

---
 rtl/rptr_handler.sv | 107 ++++++++++
 tb/tb_rptr_handler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rptr_handler.sv
// -----------------------------------------------------------------------------
// rptr_handler
// Read-side pointer and flag logic for a 2^WIDTH-entry asynchronous FIFO.
// Lives entirely in the read clock domain. It brings the write-domain Gray
// pointer across a 2-flop synchronizer, advances the binary read address and
// Gray read pointer, and produces empty / almost_empty / fill count plus a
// sticky underflow flag.
//
// Ports:
//   rclk          in   read-domain clock, all state changes on rising edge
//   rrst          in   synchronous active-low reset
//   ren           in   read request, honoured only while empty=0
//   wptr          in   Gray write pointer (asynchronous to rclk)
//   raddr         out  binary read counter; low WIDTH bits address memory
//   rptr          out  registered Gray read pointer, sent to write domain
//   wptr_sync     out  wptr after the 2-flop synchronizer
//   empty         out  FIFO empty, registered
//   almost_empty  out  fill count <= AE_LEVEL, registered
//   rcount        out  read-side fill level 0..2^WIDTH, registered
//   underflow     out  sticky, set by a read attempt while empty
// -----------------------------------------------------------------------------
module rptr_handler #(
   parameter int WIDTH    = 5,
   parameter int AE_LEVEL = 4
) (
   input  logic           rclk,
   input  logic           rrst,
   input  logic           ren,
   input  logic [WIDTH:0] wptr,
   output logic [WIDTH:0] raddr,
   output logic [WIDTH:0] rptr,
   output logic [WIDTH:0] wptr_sync,
   output logic           empty,
   output logic           almost_empty,
   output logic [WIDTH:0] rcount,
   output logic           underflow
);

   localparam logic [WIDTH:0] AE_THR = (WIDTH+1)'(AE_LEVEL);

   logic [WIDTH:0] r_wq1;
   logic [WIDTH:0] r_wptr_sync;
   logic [WIDTH:0] r_raddr;
   logic [WIDTH:0] r_rptr;
   logic           r_empty;
   logic           r_almost_empty;
   logic [WIDTH:0] r_rcount;
   logic           r_underflow;

   logic           w_rinc;
   logic [WIDTH:0] w_raddr_nxt;
   logic [WIDTH:0] w_rptr_nxt;
   logic [WIDTH:0] w_wbin;
   logic [WIDTH:0] w_diff;

   // XOR prefix from the MSB down.
   function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
      logic [WIDTH:0] b;
      b[WIDTH] = g[WIDTH];
      for (int i = WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign w_rinc      = ren & ~r_empty;
   assign w_raddr_nxt = r_raddr + {{WIDTH{1'b0}}, w_rinc};
   assign w_rptr_nxt  = (w_raddr_nxt >> 1) ^ w_raddr_nxt;
   assign w_wbin      = gray2bin(r_wptr_sync);
   // Modulo subtraction; the pointer MSB tells laps apart so equal means empty.
   assign w_diff      = w_wbin - w_raddr_nxt;

   always_ff @(posedge rclk) begin
      if (!rrst) begin
         r_wq1          <= '0;
         r_wptr_sync    <= '0;
         r_raddr        <= '0;
         r_rptr         <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_rcount       <= '0;
         r_underflow    <= 1'b0;
      end else begin
         r_wq1          <= wptr;
         r_wptr_sync    <= r_wq1;
         r_raddr        <= w_raddr_nxt;
         r_rptr         <= w_rptr_nxt;
         // Comparing against the next pointer flags empty on the same edge
         // that consumes the last entry, so there is no over-read.
         r_empty        <= (w_rptr_nxt == r_wptr_sync);
         // Uses the pre-edge synchronized pointer: may lag one cycle but
         // never overstates fill.
         r_almost_empty <= (w_diff <= AE_THR);
         r_rcount       <= w_diff;
         r_underflow    <= r_underflow | (ren & r_empty);
      end
   end

   assign raddr        = r_raddr;
   assign rptr         = r_rptr;
   assign wptr_sync    = r_wptr_sync;
   assign empty        = r_empty;
   assign almost_empty = r_almost_empty;
   assign rcount       = r_rcount;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_rptr_handler.sv
module tb_rptr_handler;

   logic       rclk;
   logic       rrst;
   logic       ren;
   logic [5:0] wptr;
   logic [5:0] raddr;
   logic [5:0] rptr;
   logic [5:0] wptr_sync;
   logic       empty;
   logic       almost_empty;
   logic [5:0] rcount;
   logic       underflow;

   int n_checks = 0;
   int n_errors = 0;

   rptr_handler #(.WIDTH(5), .AE_LEVEL(4)) dut (
      .rclk         (rclk),
      .rrst         (rrst),
      .ren          (ren),
      .wptr         (wptr),
      .raddr        (raddr),
      .rptr         (rptr),
      .wptr_sync    (wptr_sync),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rcount       (rcount),
      .underflow    (underflow)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   typedef struct packed {
      logic       rrst;
      logic       ren;
      logic [5:0] wptr;
      logic [5:0] raddr;
      logic [5:0] rptr;
      logic [5:0] wsync;
      logic       empty;
      logic       ae;
      logic [5:0] rcount;
      logic       uf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rs, input logic re, input int wp,
                               input int a, input int rp, input int ws,
                               input logic e, input logic ae, input int c,
                               input logic uf);
      vec_t v;
      v.rrst = rs; v.ren = re; v.wptr = 6'(wp);
      v.raddr = 6'(a); v.rptr = 6'(rp); v.wsync = 6'(ws);
      v.empty = e; v.ae = ae; v.rcount = 6'(c); v.uf = uf;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic rs, input logic re, input logic [5:0] wp);
      @(negedge rclk);
      rrst = rs; ren = re; wptr = wp;
      @(posedge rclk);
      #1;
   endtask

   function automatic int gray(input int b);
      return (b ^ (b >> 1)) & 63;
   endfunction

   initial begin
      rrst = 1'b0; ren = 1'b1; wptr = '0;

      // reset
      vecs.push_back(mk(0,1, 0,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(0,1, 0,  0,0, 0, 1,1, 0,0));
      // sync latency: wptr gray 000010 = bin 3
      vecs.push_back(mk(1,0, 2,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(1,0, 2,  0,0, 2, 1,1, 0,0));
      vecs.push_back(mk(1,0, 2,  0,0, 2, 0,1, 3,0));
      // wptr gray 000101 = bin 6
      vecs.push_back(mk(1,0, 5,  0,0, 2, 0,1, 3,0));
      vecs.push_back(mk(1,0, 5,  0,0, 5, 0,1, 3,0));
      vecs.push_back(mk(1,0, 5,  0,0, 5, 0,0, 6,0));
      // drain
      vecs.push_back(mk(1,1, 5,  1,1, 5, 0,0, 5,0));
      vecs.push_back(mk(1,1, 5,  2,3, 5, 0,1, 4,0));
      vecs.push_back(mk(1,1, 5,  3,2, 5, 0,1, 3,0));
      vecs.push_back(mk(1,1, 5,  4,6, 5, 0,1, 2,0));
      vecs.push_back(mk(1,1, 5,  5,7, 5, 0,1, 1,0));
      vecs.push_back(mk(1,1, 5,  6,5, 5, 1,1, 0,0));
      vecs.push_back(mk(1,1, 5,  6,5, 5, 1,1, 0,1));
      vecs.push_back(mk(1,0, 5,  6,5, 5, 1,1, 0,1));
      // reset, then wptr bin 10 (gray 001111)
      vecs.push_back(mk(0,0, 5,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0,15, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0,15, 0,0,10,0));
      // mid-op reset with ren=1: no increment taken
      vecs.push_back(mk(0,1,15,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0, 0, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0,15, 1,1, 0,0));
      vecs.push_back(mk(1,0,15,  0,0,15, 0,0,10,0));
      // almost_empty boundary
      vecs.push_back(mk(1,1,15,  1,1,15, 0,0, 9,0));
      vecs.push_back(mk(1,1,15,  2,3,15, 0,0, 8,0));
      vecs.push_back(mk(1,1,15,  3,2,15, 0,0, 7,0));
      vecs.push_back(mk(1,1,15,  4,6,15, 0,0, 6,0));
      vecs.push_back(mk(1,1,15,  5,7,15, 0,0, 5,0));
      vecs.push_back(mk(1,1,15,  6,5,15, 0,1, 4,0));
      // wptr = gray(40) = 111100
      vecs.push_back(mk(1,0,60,  6,5,15, 0,1, 4,0));
      vecs.push_back(mk(1,0,60,  6,5,60, 0,1, 4,0));
      vecs.push_back(mk(1,0,60,  6,5,60, 0,0,34,0));

      foreach (vecs[i]) begin
         step(vecs[i].rrst, vecs[i].ren, vecs[i].wptr);
         chk($sformatf("v%0d raddr", i),     raddr,        vecs[i].raddr);
         chk($sformatf("v%0d rptr", i),      rptr,         vecs[i].rptr);
         chk($sformatf("v%0d wptr_sync", i), wptr_sync,    vecs[i].wsync);
         chk($sformatf("v%0d empty", i),     empty,        vecs[i].empty);
         chk($sformatf("v%0d almost", i),    almost_empty, vecs[i].ae);
         chk($sformatf("v%0d rcount", i),    rcount,       vecs[i].rcount);
         chk($sformatf("v%0d underflow", i), underflow,    vecs[i].uf);
      end

      // bring raddr up to 40
      for (int i = 1; i <= 34; i++) begin
         step(1'b1, 1'b1, 6'd60);
         chk($sformatf("fill%0d raddr", i),  raddr,  6 + i);
         chk($sformatf("fill%0d rcount", i), rcount, 34 - i);
         chk($sformatf("fill%0d empty", i),  empty,  (i == 34) ? 1 : 0);
         chk($sformatf("fill%0d almost", i), almost_empty, ((34 - i) <= 4) ? 1 : 0);
      end
      chk("at40 rptr", rptr, 6'b111100);

      // wptr bin 1 on the next lap: fill = 25
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 6'd1);
         chk($sformatf("lap%0d rcount", i), rcount, (i == 3) ? 25 : 0);
         chk($sformatf("lap%0d empty", i),  empty,  (i == 3) ? 0 : 1);
      end
      chk("lap almost", almost_empty, 0);

      // 25 reads across the wrap
      for (int i = 1; i <= 25; i++) begin
         step(1'b1, 1'b1, 6'd1);
         chk($sformatf("wrap%0d raddr", i),  raddr,  (40 + i) & 63);
         chk($sformatf("wrap%0d rptr", i),   rptr,   gray((40 + i) & 63));
         chk($sformatf("wrap%0d rcount", i), rcount, 25 - i);
         chk($sformatf("wrap%0d empty", i),  empty,  (i == 25) ? 1 : 0);
         if (i == 23) chk("wrap rptr63", rptr, 6'b100000);
         if (i == 24) chk("wrap rptr0",  rptr, 6'b000000);
      end
      step(1'b1, 1'b0, 6'd1);
      chk("wrap end raddr", raddr, 1);
      chk("wrap end rptr", rptr, 1);
      chk("wrap end underflow", underflow, 0);
      chk("wrap end empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
